// File: rtl/img_fetch_gray.sv
// Raster-order frame fetcher: issues source reads, tracks them through the memory
// latency and converts returning RGB332 pixels to 8-bit luminance for the Sobel stage.
module img_fetch_gray #(
  parameter int IMG_W  = 320,
  parameter int IMG_H  = 240,
  parameter int ADDR_W = 17,
  parameter int RD_LAT = 2
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic              cont,
  input  logic              stall,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_rd,
  input  logic [7:0]        mem_data,
  output logic [7:0]        rd_data,
  output logic              val,
  output logic              sof,
  output logic              busy,
  output logic              frame_done
);

  localparam int NPIX = IMG_W * IMG_H;
  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(NPIX - 1);

  typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;

  state_t            state_reg, state_next;
  logic [ADDR_W-1:0] count_reg, count_next;
  logic              first_reg, first_next;
  logic              issue;

  logic [RD_LAT-1:0] pv_reg;
  logic [RD_LAT-1:0] ps_reg;
  logic              tap_v;
  logic              tap_s;

  logic [2:0] px_r, px_g;
  logic [1:0] px_b;
  logic [7:0] r8, g8, b8;
  logic [7:0] gray;

  logic [7:0] rd_data_reg;
  logic       val_reg;
  logic       sof_reg;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_reg <= IDLE;
      count_reg <= '0;
      first_reg <= 1'b0;
    end else begin
      state_reg <= state_next;
      count_reg <= count_next;
      first_reg <= first_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    count_next = count_reg;
    first_next = first_reg;
    issue      = 1'b0;
    busy       = 1'b0;
    frame_done = 1'b0;
    case (state_reg)
      IDLE: begin
        if (start) begin
          state_next = RUN;
          count_next = '0;
          first_next = 1'b1;
        end
      end
      RUN: begin
        busy  = 1'b1;
        issue = ~stall;
        if (issue) begin
          first_next = 1'b0;
          // The counter parks on the last address so mem_addr never leaves the frame.
          if (count_reg == LAST_ADDR) state_next = DRAIN;
          else                        count_next = count_reg + ADDR_W'(1);
        end
      end
      DRAIN: begin
        busy = 1'b1;
        if (pv_reg == '0) state_next = DONE;
      end
      DONE: begin
        frame_done = 1'b1;
        count_next = '0;
        if (cont) begin
          state_next = RUN;
          first_next = 1'b1;
        end else begin
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  assign mem_rd   = issue;
  assign mem_addr = count_reg;

  // Read tracker: valid and start-of-frame bits travel alongside each outstanding read.
  generate
    for (genvar gi = 0; gi < RD_LAT; gi++) begin : g_track
      always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
          pv_reg[gi] <= 1'b0;
          ps_reg[gi] <= 1'b0;
        end else if (gi == 0) begin
          pv_reg[gi] <= issue;
          ps_reg[gi] <= issue & first_reg;
        end else begin
          pv_reg[gi] <= pv_reg[(gi > 0) ? gi - 1 : 0];
          ps_reg[gi] <= ps_reg[(gi > 0) ? gi - 1 : 0];
        end
      end
    end
  endgenerate

  assign tap_v = pv_reg[RD_LAT-1];
  assign tap_s = ps_reg[RD_LAT-1];

  assign px_r = mem_data[7:5];
  assign px_g = mem_data[4:2];
  assign px_b = mem_data[1:0];
  assign r8   = {px_r, px_r, px_r[2:1]};
  assign g8   = {px_g, px_g, px_g[2:1]};
  assign b8   = {px_b, px_b, px_b, px_b};
  // Weights sum to 256, so the 16-bit sum cannot overflow and >>8 stays within 8 bits.
  assign gray = 8'(({8'd0, r8} * 16'd77 + {8'd0, g8} * 16'd150 + {8'd0, b8} * 16'd29) >> 8);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rd_data_reg <= '0;
      val_reg     <= 1'b0;
      sof_reg     <= 1'b0;
    end else begin
      val_reg <= tap_v;
      sof_reg <= tap_v & tap_s;
      if (tap_v) rd_data_reg <= gray;
    end
  end

  assign rd_data = rd_data_reg;
  assign val     = val_reg;
  assign sof     = sof_reg;

endmodule

// File: tb/tb_img_fetch_gray.sv
// Scoreboard bench for img_fetch_gray on a reduced 16x4 frame, plus RD_LAT=1/4 instances.
module tb_img_fetch_gray;

  localparam int TW = 16;
  localparam int TH = 4;
  localparam int N  = TW * TH;
  localparam int AW = 17;
  localparam int LAT = 2;

  logic clk = 1'b0;
  logic reset, start, cont, stall, start_sw;

  logic [AW-1:0] mem_addr, mem_addr_1, mem_addr_4;
  logic          mem_rd, mem_rd_1, mem_rd_4;
  logic [7:0]    mem_data, mem_data_1, mem_data_4;
  logic [7:0]    rd_data, rd_data_1, rd_data_4;
  logic          val, val_1, val_4;
  logic          sof, sof_1, sof_4;
  logic          busy, busy_1, busy_4;
  logic          frame_done, frame_done_1, frame_done_4;

  logic [7:0] mem_img [0:N-1];
  logic [7:0] p2 [2];
  logic [7:0] p1 [1];
  logic [7:0] p4 [4];

  typedef struct {int cyc; logic s; logic [7:0] d;} exp_t;
  exp_t q[$];

  int n_checks = 0;
  int n_fail   = 0;
  int cyc = 0, exp_addr = 0, last_val = 0, sof_cyc = 0, pix = 0;
  int tot_vals = 0, tot_sof = 0, tot_done = 0;
  int rd1 = -1, v1 = -1, rd4 = -1, v4 = -1, vals1 = 0, vals4 = 0, done1 = 0, done4 = 0;
  logic prev_done = 1'b0, prev_cont = 1'b0;
  logic [7:0] cap [5];

  always #5 clk = ~clk;

  img_fetch_gray #(.IMG_W(TW), .IMG_H(TH), .ADDR_W(AW), .RD_LAT(LAT)) u_dut (
    .clk(clk), .reset(reset), .start(start), .cont(cont), .stall(stall),
    .mem_addr(mem_addr), .mem_rd(mem_rd), .mem_data(mem_data), .rd_data(rd_data),
    .val(val), .sof(sof), .busy(busy), .frame_done(frame_done));

  img_fetch_gray #(.IMG_W(TW), .IMG_H(TH), .ADDR_W(AW), .RD_LAT(1)) u_lat1 (
    .clk(clk), .reset(reset), .start(start_sw), .cont(1'b0), .stall(1'b0),
    .mem_addr(mem_addr_1), .mem_rd(mem_rd_1), .mem_data(mem_data_1), .rd_data(rd_data_1),
    .val(val_1), .sof(sof_1), .busy(busy_1), .frame_done(frame_done_1));

  img_fetch_gray #(.IMG_W(TW), .IMG_H(TH), .ADDR_W(AW), .RD_LAT(4)) u_lat4 (
    .clk(clk), .reset(reset), .start(start_sw), .cont(1'b0), .stall(1'b0),
    .mem_addr(mem_addr_4), .mem_rd(mem_rd_4), .mem_data(mem_data_4), .rd_data(rd_data_4),
    .val(val_4), .sof(sof_4), .busy(busy_4), .frame_done(frame_done_4));

  // Source memories: registered read followed by extra delay stages up to each latency.
  always @(posedge clk) begin
    p2[0] <= mem_img[mem_addr[5:0]];
    p2[1] <= p2[0];
    p1[0] <= mem_img[mem_addr_1[5:0]];
    p4[0] <= mem_img[mem_addr_4[5:0]];
    for (int i = 1; i < 4; i++) p4[i] <= p4[i-1];
  end
  assign mem_data   = p2[1];
  assign mem_data_1 = p1[0];
  assign mem_data_4 = p4[3];

  function automatic logic [7:0] gray_ref(input logic [7:0] p);
    int r8, g8, b8;
    r8 = {p[7:5], p[7:5], p[7:6]};
    g8 = {p[4:2], p[4:2], p[4:3]};
    b8 = {p[1:0], p[1:0], p[1:0], p[1:0]};
    return 8'((77 * r8 + 150 * g8 + 29 * b8) / 256);
  endfunction

  task automatic check(input string tag, input int obs, input int exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  task automatic check_idle(input string tag);
    check({tag, "_addr"}, mem_addr, 0);
    check({tag, "_rd"}, mem_rd, 0);
    check({tag, "_data"}, rd_data, 0);
    check({tag, "_val"}, val, 0);
    check({tag, "_sof"}, sof, 0);
    check({tag, "_busy"}, busy, 0);
    check({tag, "_done"}, frame_done, 0);
    $display("reset state %s checked", tag);
  endtask

  task automatic pulse_start(input bit sw);
    @(posedge clk); #1;
    if (sw) start_sw = 1'b1; else start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    start_sw = 1'b0;
  endtask

  task automatic wait_frames(input int k, input int budget, input int pct);
    int target;
    int n;
    target = tot_done + k;
    n = 0;
    while (tot_done < target && n < budget) begin
      @(posedge clk); #1;
      stall = (pct > 0) && ($urandom_range(0, 99) < pct);
      n++;
    end
    stall = 1'b0;
    check("frame_timeout", int'(tot_done >= target), 1);
  endtask

  // Monitor: scoreboard push on every read issue, pop/compare on every val.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      cyc++;
      if (!reset) begin
        q.delete();
        exp_addr  = 0;
        prev_done = 1'b0;
      end else begin
        if (prev_done && prev_cont && !stall) check("cont_restart_rd", mem_rd, 1);
        prev_done = frame_done;
        prev_cont = cont;
        if (mem_rd) begin
          check("addr", mem_addr, exp_addr);
          e.cyc = cyc;
          e.s   = (exp_addr == 0);
          e.d   = gray_ref(mem_img[exp_addr]);
          q.push_back(e);
          exp_addr = (exp_addr == N - 1) ? 0 : exp_addr + 1;
        end
        if (val) begin
          if (q.size() == 0) begin
            check("spurious_val", val, 0);
          end else begin
            e = q.pop_front();
            check("data", rd_data, e.d);
            check("sof", sof, e.s);
            check("latency", cyc - e.cyc, LAT + 1);
          end
          tot_vals++;
          if (sof) begin
            tot_sof++;
            sof_cyc = cyc;
            pix = 0;
          end
          if (pix < 5) cap[pix] = rd_data;
          pix++;
          last_val = cyc;
        end else begin
          check("sof_without_val", sof, 0);
        end
        if (frame_done) begin
          tot_done++;
          check("done_after_last_val", cyc - last_val, 1);
          check("done_rd", mem_rd, 0);
          check("done_busy", busy, 0);
          check("done_queue_empty", q.size(), 0);
          $display("frame_done at cycle %0d, total vals %0d", cyc, tot_vals);
        end
      end
      if (mem_rd_1 && rd1 < 0) rd1 = cyc;
      if (val_1 && v1 < 0) v1 = cyc;
      if (mem_rd_4 && rd4 < 0) rd4 = cyc;
      if (val_4 && v4 < 0) v4 = cyc;
      if (val_1) vals1++;
      if (val_4) vals4++;
      if (frame_done_1) done1++;
      if (frame_done_4) done4++;
    end
  end

  initial begin
    int v0, s0, d0, n;
    for (int i = 0; i < N; i++) mem_img[i] = 8'(i);
    mem_img[0] = 8'hFF;
    mem_img[1] = 8'h00;
    mem_img[2] = 8'hE0;
    mem_img[3] = 8'h1C;
    mem_img[4] = 8'h03;
    reset = 1'b0; start = 1'b0; cont = 1'b0; stall = 1'b0; start_sw = 1'b0;
    repeat (3) @(posedge clk);
    #1 check_idle("por");
    reset = 1'b1;

    // Basic frame, no stall
    v0 = tot_vals; s0 = tot_sof;
    pulse_start(1'b0);
    wait_frames(1, 500, 0);
    check("basic_vals", tot_vals - v0, N);
    check("basic_sof", tot_sof - s0, 1);
    check("basic_no_gap", last_val - sof_cyc, N - 1);
    check("conv_ff", cap[0], 255);
    check("conv_00", cap[1], 0);
    check("conv_red", cap[2], 76);
    check("conv_green", cap[3], 149);
    check("conv_blue", cap[4], 28);
    $display("basic frame: vals %0d", tot_vals - v0);

    // Random 30% stall
    v0 = tot_vals; s0 = tot_sof;
    pulse_start(1'b0);
    wait_frames(1, 2000, 30);
    check("stall_vals", tot_vals - v0, N);
    check("stall_sof", tot_sof - s0, 1);
    $display("stall frame: vals %0d", tot_vals - v0);

    // Continuous: two frames back to back
    v0 = tot_vals; s0 = tot_sof; d0 = tot_done;
    cont = 1'b1;
    pulse_start(1'b0);
    wait_frames(1, 1000, 0);
    cont = 1'b0;
    wait_frames(1, 1000, 0);
    repeat (20) @(posedge clk);
    #1;
    check("cont_done", tot_done - d0, 2);
    check("cont_vals", tot_vals - v0, 2 * N);
    check("cont_sof", tot_sof - s0, 2);
    check("cont_idle_busy", busy, 0);
    $display("continuous: frames %0d vals %0d", tot_done - d0, tot_vals - v0);

    // Reset in the middle of a frame
    pulse_start(1'b0);
    n = 0;
    while (!(mem_rd && mem_addr >= 30) && n < 500) begin
      @(posedge clk); #1;
      n++;
    end
    check("midreset_reach", int'(n < 500), 1);
    reset = 1'b0;
    #1 check_idle("midreset");
    repeat (3) @(posedge clk);
    #1 reset = 1'b1;
    v0 = tot_vals; d0 = tot_done;
    repeat (10) @(posedge clk);
    #1;
    check("midreset_no_val", tot_vals - v0, 0);
    check("midreset_no_done", tot_done - d0, 0);
    s0 = tot_sof;
    pulse_start(1'b0);
    wait_frames(1, 500, 0);
    check("post_reset_vals", tot_vals - v0, N);
    check("post_reset_sof", tot_sof - s0, 1);
    $display("post-reset frame: vals %0d", tot_vals - v0);

    // Latency sweep with start pulses during RUN
    pulse_start(1'b1);
    repeat (20) @(posedge clk);
    pulse_start(1'b1);
    repeat (5) @(posedge clk);
    pulse_start(1'b1);
    repeat (150) @(posedge clk);
    #1;
    check("lat1_latency", v1 - rd1, 2);
    check("lat4_latency", v4 - rd4, 5);
    check("lat1_done", done1, 1);
    check("lat4_done", done4, 1);
    check("lat1_vals", vals1, N);
    check("lat4_vals", vals4, N);
    $display("latency sweep: lat1 %0d lat4 %0d", v1 - rd1, v4 - rd4);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/img_fetch_gray.md
Name: img_fetch_gray

Overview:
- Upstream feeder for the Sobel compute stage.
- Scans the source frame memory (RGB332, 320x240, one byte per pixel) in raster order and converts each pixel to 8-bit luminance.
- Presents the result as the rd_data/val stream that the compute stage consumes. It advances only on val and has no back-pressure, so pacing is done here via stall.

Parameters:
- IMG_W, 320, pixels per line
- IMG_H, 240, lines per frame
- ADDR_W, 17, source memory address width (must satisfy 2^ADDR_W >= IMG_W*IMG_H)
- RD_LAT, 2, source memory read latency in cycles, legal range 1..4

Ports:
- clk  in  1  system clock
- reset  in  1  asynchronous, active-low reset
- start  in  1  one-cycle pulse that begins a frame scan; sampled only in IDLE
- cont  in  1  when 1, the next frame restarts automatically after frame_done
- stall  in  1  when 1, suppresses new read issue; in-flight reads still complete
- mem_addr  out  ADDR_W  source memory read address
- mem_rd  out  1  source memory read strobe
- mem_data  in  8  RGB332 pixel {r[2:0],g[2:0],b[1:0]}, valid RD_LAT cycles after mem_rd
- rd_data  out  8  grayscale pixel to the compute stage
- val  out  1  rd_data valid, one pixel per asserted cycle
- sof  out  1  asserted with val on pixel 0 of each frame only
- busy  out  1  high in RUN and DRAIN
- frame_done  out  1  one-cycle pulse after the last pixel's val

Behaviour:
- Clock and reset: one clock; reset is asynchronous and active-low.
- Reset values: all outputs 0, FSM in IDLE, address counter 0, in-flight pipe cleared.
- Reset mid-frame: in-flight data is discarded; no val or frame_done is produced afterwards.
- FSM states: IDLE, RUN, DRAIN, DONE.
- IDLE:
  - start=1 -> RUN, address counter set to 0.
  - Any other input is ignored.
- RUN:
  - Each cycle, mem_rd = ~stall.
  - When mem_rd=1, mem_addr holds the current count and the count increments on that edge.
  - After the cycle that issues address IMG_W*IMG_H-1 (76799) -> DRAIN.
  - start is ignored in RUN.
  - stall may toggle on any cycle; mem_addr holds while stalled.
- DRAIN:
  - mem_rd=0.
  - Waits until the in-flight tracker is empty -> DONE.
- DONE:
  - frame_done=1 for exactly one cycle.
  - Next state is RUN with count 0 if cont=1, else IDLE.
  - With cont=1 the first read of the new frame issues on the cycle after DONE.
- In-flight tracker: a RD_LAT-deep shift register of mem_rd bits. Its tap at depth RD_LAT qualifies mem_data.
- Conversion pipeline (1 register stage):
  - R8 = {r,r,r[2:1]}, G8 = {g,g,g[2:1]}, B8 = {b,b,b,b}.
  - gray = (77*R8 + 150*G8 + 29*B8) >> 8, with a 16-bit unsigned intermediate; no overflow is possible since the weights sum to 256.
  - rd_data and val are registered together.
- Latency: val rises exactly RD_LAT+1 cycles after the matching mem_rd cycle. Order is preserved, and exactly one val is produced per mem_rd.
- Holding: rd_data keeps its last value when val=0.
- sof:
  - Set on the val for the first read issued after entering RUN from IDLE or DONE.
  - A stall before the first issue does not move sof.
- busy: high in RUN and DRAIN, low in IDLE and DONE.
- Simultaneous start and reset deassertion: start is honoured only on a cycle where reset is already high at the clock edge.
- mem_addr never exceeds IMG_W*IMG_H-1.

Test Plan:
- Basic frame: reset, start pulse, stall=0, memory with mem_data = addr[7:0] -> 76800 val pulses with no gaps; first val at RD_LAT+1 (=3) cycles after first mem_rd; sof on first only; frame_done 1 cycle after last val.
- Conversion values: 8'hFF -> 255, 8'h00 -> 0, 8'hE0 (pure red, R8=255) -> 76, 8'h1C (green) -> 149, 8'h03 (blue) -> 28.
- Stall: random 30% stall during RUN -> val count still 76800; mem_addr sequence strictly 0..76799 with no skips or repeats; val gaps mirror the mem_rd gaps delayed by 3 cycles.
- Continuous: cont=1, two frames -> frame_done pulses twice, 76800 vals per frame, sof exactly twice, one DONE cycle between frames with mem_rd=0.
- Reset mid-frame: assert reset at pixel 1000 -> all outputs 0 immediately, no further val; after release, start -> clean frame beginning at addr 0 with sof.
- Latency sweep: RD_LAT=1 and 4 -> first val at 2 and 5 cycles after mem_rd respectively; start pulses during RUN ignored (one frame_done only).
